// File: rtl/operand_read_stage_pkg.sv
// Shared types and sizing for the operand read stage.
// Holds the reservation-station entry and the payload kept in each stage slot.
package operand_read_stage_pkg;

    localparam int PHY_REGS   = 64;
    localparam int PHY_WIDTH  = $clog2(PHY_REGS);
    localparam int DATA_WIDTH = 32;
    localparam int NUM_WB     = 2;

    typedef struct packed {
        logic [7:0]           opcode;
        logic [5:0]           rob_idx;
        logic [PHY_WIDTH-1:0] rd_phy;
        logic [PHY_WIDTH-1:0] rs1_phy;
        logic [PHY_WIDTH-1:0] rs2_phy;
    } RS_ENTRY_t;

    typedef struct packed {
        RS_ENTRY_t             entry;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic                  valid;
    } EX_PAYLOAD_t;

endpackage

// File: rtl/operand_read_stage_if.sv
// Bundle of issue, PRF, writeback and execute-side signals around the stage.
// Issue and execute both use valid/ready: a transfer happens on a clock edge where valid and ready are both high.
interface operand_read_stage_if;
    import operand_read_stage_pkg::*;

    logic                                  flush;
    RS_ENTRY_t                             issue_instruction;
    logic                                  issue_valid;
    logic                                  issue_ready;
    logic [PHY_WIDTH-1:0]                  prf_rs1_addr;
    logic [PHY_WIDTH-1:0]                  prf_rs2_addr;
    logic [DATA_WIDTH-1:0]                 prf_rs1_data;
    logic [DATA_WIDTH-1:0]                 prf_rs2_data;
    logic [NUM_WB-1:0]                     wb_valid;
    logic [NUM_WB-1:0][PHY_WIDTH-1:0]      wb_rd_phy;
    logic [NUM_WB-1:0][DATA_WIDTH-1:0]     wb_data;
    RS_ENTRY_t                             ex_instruction;
    logic [DATA_WIDTH-1:0]                 ex_rs1_data;
    logic [DATA_WIDTH-1:0]                 ex_rs2_data;
    logic                                  ex_valid;
    logic                                  ex_ready;
    logic                                  overflow_err;

    modport master (
        output flush, issue_instruction, issue_valid, prf_rs1_data, prf_rs2_data,
               wb_valid, wb_rd_phy, wb_data, ex_ready,
        input  issue_ready, prf_rs1_addr, prf_rs2_addr, ex_instruction,
               ex_rs1_data, ex_rs2_data, ex_valid, overflow_err
    );

    modport slave (
        input  flush, issue_instruction, issue_valid, prf_rs1_data, prf_rs2_data,
               wb_valid, wb_rd_phy, wb_data, ex_ready,
        output issue_ready, prf_rs1_addr, prf_rs2_addr, ex_instruction,
               ex_rs1_data, ex_rs2_data, ex_valid, overflow_err
    );

endinterface

// File: rtl/operand_read_stage_bypass.sv
// Combinational operand select for one source: zero register, then writeback
// bypass (lowest port wins), then register-file data.
module operand_read_stage_bypass
    import operand_read_stage_pkg::*;
(
    input  logic [PHY_WIDTH-1:0]              phy,
    input  logic [DATA_WIDTH-1:0]             prf_data,
    input  logic [NUM_WB-1:0]                 wb_valid,
    input  logic [NUM_WB-1:0][PHY_WIDTH-1:0]  wb_rd_phy,
    input  logic [NUM_WB-1:0][DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0]             data
);

    logic hit;

    always_comb begin
        data = prf_data;
        hit  = 1'b0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (!hit && wb_valid[i] && (wb_rd_phy[i] == phy)) begin
                data = wb_data[i];
                hit  = 1'b1;
            end
        end
        if (phy == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/operand_read_stage.sv
// Issue-to-execute stage: captures operands at accept and feeds the execution
// unit through an output slot backed by a one-entry skid slot.
module operand_read_stage
    import operand_read_stage_pkg::*;
#(
    parameter int TYPE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    operand_read_stage_if.slave   bus
);

    // Unit flavour is informational only; anything beyond BRU is not a known unit.
    if (TYPE > 2) begin : g_type_out_of_range
    end

    EX_PAYLOAD_t           out_q, out_d;
    EX_PAYLOAD_t           skd_q, skd_d;
    EX_PAYLOAD_t           new_entry;
    logic                  issue_ready_q;
    logic                  overflow_q;
    logic                  accept;
    logic                  drain;
    logic [DATA_WIDTH-1:0] rs1_val;
    logic [DATA_WIDTH-1:0] rs2_val;

    assign bus.prf_rs1_addr = bus.issue_instruction.rs1_phy;
    assign bus.prf_rs2_addr = bus.issue_instruction.rs2_phy;

    operand_read_stage_bypass u_rs1_bypass (
        .phy       (bus.issue_instruction.rs1_phy),
        .prf_data  (bus.prf_rs1_data),
        .wb_valid  (bus.wb_valid),
        .wb_rd_phy (bus.wb_rd_phy),
        .wb_data   (bus.wb_data),
        .data      (rs1_val)
    );

    operand_read_stage_bypass u_rs2_bypass (
        .phy       (bus.issue_instruction.rs2_phy),
        .prf_data  (bus.prf_rs2_data),
        .wb_valid  (bus.wb_valid),
        .wb_rd_phy (bus.wb_rd_phy),
        .wb_data   (bus.wb_data),
        .data      (rs2_val)
    );

    assign accept    = bus.issue_valid && issue_ready_q && !bus.flush;
    assign drain     = out_q.valid && bus.ex_ready;
    assign new_entry = '{entry: bus.issue_instruction, rs1_data: rs1_val,
                         rs2_data: rs2_val, valid: 1'b1};

    // The skid slot is always older than a new accept, so it refills OUT first.
    always_comb begin
        out_d = out_q;
        skd_d = skd_q;
        if (bus.flush) begin
            out_d.valid = 1'b0;
            skd_d.valid = 1'b0;
        end else if (!out_q.valid || drain) begin
            if (skd_q.valid) begin
                out_d = skd_q;
                if (accept) begin
                    skd_d = new_entry;
                end else begin
                    skd_d.valid = 1'b0;
                end
            end else if (accept) begin
                out_d = new_entry;
            end else begin
                out_d.valid = 1'b0;
            end
        end else if (accept) begin
            skd_d = new_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q         <= '0;
            skd_q         <= '0;
            issue_ready_q <= 1'b1;
            overflow_q    <= 1'b0;
        end else begin
            out_q         <= out_d;
            skd_q         <= skd_d;
            issue_ready_q <= !skd_d.valid;
            if (bus.issue_valid && !issue_ready_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.issue_ready    = issue_ready_q;
    assign bus.overflow_err   = overflow_q;
    assign bus.ex_valid       = out_q.valid;
    assign bus.ex_instruction = out_q.entry;
    assign bus.ex_rs1_data    = out_q.rs1_data;
    assign bus.ex_rs2_data    = out_q.rs2_data;

endmodule
